// File: rtl/dly_pkg.sv
// -----------------------------------------------------------------------------
// dly_pkg
// Constants and types shared by the delay generator and the delay
// measurement block (delay_meas).
//   MS_W_DEF          : default width of ms counters, limits and results
//   TICKS_PER_MS_DEF  : default i_clk_1k cycles per counted ms
//   TICKS_PER_MS_SIM  : shortened tick count for simulation builds
//   state_e           : measurement FSM state encoding
// -----------------------------------------------------------------------------
package dly_pkg;

  localparam int MS_W_DEF         = 12;
  localparam int TICKS_PER_MS_DEF = 32;
  localparam int TICKS_PER_MS_SIM = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for one asynchronous level input.
//   i_clk_1k : destination clock
//   i_rst    : asynchronous active-high reset, clears both flops to 0
//   i_d      : asynchronous input level
//   o_q      : synchronized level, two clocks behind i_d
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic i_clk_1k,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;

  always_ff @(posedge i_clk_1k or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      meta_q <= i_d;
      o_q    <= meta_q;
    end
  end

endmodule

// File: rtl/delay_meas.sv
// -----------------------------------------------------------------------------
// delay_meas
// Measures elapsed ms from a start event (rising i_start) to a done event
// (i_done high) and flags a timeout when a programmed limit is reached first.
//   i_clk_1k    : sole clock
//   i_rst       : asynchronous active-high reset
//   i_start     : async level; rising edge starts, low level aborts
//   i_done      : async level; high ends the measurement
//   i_limit     : timeout in ms, latched at the start edge; 0 = no timeout
//   o_meas      : measured ms (or limit on timeout), held until next start
//   o_valid     : o_meas holds a completed measurement
//   o_timeout   : limit reached before done
//   o_busy      : measurement in progress
//   o_dbg_state : current FSM state, for observation only
// Handshake: there is no ready; o_valid/o_timeout are level flags that stay
// asserted until the next start edge clears them together with o_busy rising.
// -----------------------------------------------------------------------------
module delay_meas
  import dly_pkg::*;
#(
  parameter int TICKS_PER_MS = TICKS_PER_MS_DEF,
  parameter int MS_W         = MS_W_DEF
) (
  input  logic            i_clk_1k,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_done,
  input  logic [MS_W-1:0] i_limit,
  output logic [MS_W-1:0] o_meas,
  output logic            o_valid,
  output logic            o_timeout,
  output logic            o_busy,
  output state_e          o_dbg_state
);

  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS_PER_MS - 1);
  localparam logic [MS_W-1:0] MS_MAX    = '1;

  logic s_start, s_done, s_start_d, rise_q;
  logic first_q;
  logic [TW-1:0]   tick_q;
  logic [MS_W-1:0] ms_q, limit_q;
  state_e state_q, state_d;
  logic [MS_W-1:0] meas_d;
  logic valid_d, tout_d, busy_d;

  sync_2ff u_sync_start (
    .i_clk_1k (i_clk_1k),
    .i_rst    (i_rst),
    .i_d      (i_start),
    .o_q      (s_start)
  );

  sync_2ff u_sync_done (
    .i_clk_1k (i_clk_1k),
    .i_rst    (i_rst),
    .i_d      (i_done),
    .o_q      (s_done)
  );

  // Start edge detect; the rise is registered so the FSM sees a clean pulse.
  always_ff @(posedge i_clk_1k or posedge i_rst) begin
    if (i_rst) begin
      s_start_d <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      s_start_d <= s_start;
      rise_q    <= s_start & ~s_start_d;
    end
  end

  // Tick / ms counters and limit latch. first_q marks the RUN entry cycle,
  // in which done is deliberately ignored.
  always_ff @(posedge i_clk_1k or posedge i_rst) begin
    if (i_rst) begin
      tick_q  <= '0;
      ms_q    <= '0;
      limit_q <= '0;
      first_q <= 1'b0;
    end else if (rise_q) begin
      tick_q  <= '0;
      ms_q    <= '0;
      limit_q <= i_limit;
      first_q <= 1'b1;
    end else if (state_q == RUN) begin
      first_q <= 1'b0;
      if (tick_q == TICK_LAST) begin
        tick_q <= '0;
        if (ms_q != MS_MAX) ms_q <= ms_q + 1'b1;
      end else begin
        tick_q <= tick_q + 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk_1k or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: a rise restarts from any state; RUN exits in priority
  // order abort, done, timeout.
  always_comb begin
    state_d = state_q;
    if (rise_q) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (!s_start)                                state_d = IDLE;
      else if (s_done && !first_q)                 state_d = DONE;
      else if ((limit_q != '0) && (ms_q == limit_q)) state_d = TOUT;
    end
  end

  // Output next values; registered below so no output is combinational.
  always_comb begin
    meas_d  = o_meas;
    valid_d = o_valid;
    tout_d  = o_timeout;
    busy_d  = o_busy;
    if (rise_q) begin
      meas_d  = '0;
      valid_d = 1'b0;
      tout_d  = 1'b0;
      busy_d  = 1'b1;
    end else if (state_q == RUN) begin
      case (state_d)
        IDLE: begin
          valid_d = 1'b0;
          tout_d  = 1'b0;
          busy_d  = 1'b0;
        end
        DONE: begin
          meas_d  = ms_q;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end
        TOUT: begin
          meas_d  = limit_q;
          tout_d  = 1'b1;
          busy_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk_1k or posedge i_rst) begin
    if (i_rst) begin
      o_meas    <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_meas    <= meas_d;
      o_valid   <= valid_d;
      o_timeout <= tout_d;
      o_busy    <= busy_d;
    end
  end

  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_delay_meas.sv
// -----------------------------------------------------------------------------
// tb_delay_meas
// Scoreboarded bench for delay_meas (TICKS_PER_MS=2, MS_W=12). Each start
// pushes the expected busy-rise cycle and the expected end-of-measurement
// (cycle, flags, ms value) computed from elapsed-time arithmetic; a negedge
// monitor pops and compares on every o_busy transition.
// Timing model: inputs change just after edge e. Start is seen by the FSM
// 4 edges later (RUN entry cycle k=0 begins at edge e0+4); a done or fall at
// e0+D is seen in RUN cycle k=D-2; the resulting outputs appear one edge
// after that cycle.
// -----------------------------------------------------------------------------
module tb_delay_meas;
  import dly_pkg::*;

  localparam int TPM    = 2;
  localparam int MS_W   = 12;
  localparam int MS_MAX = (1 << MS_W) - 1;
  localparam int INF    = 32'h3fff_ffff;
  localparam int EW     = 2 + MS_W + 32;

  logic            i_clk_1k = 1'b0;
  logic            i_rst    = 1'b1;
  logic            i_start  = 1'b0;
  logic            i_done   = 1'b0;
  logic [MS_W-1:0] i_limit  = '0;
  logic [MS_W-1:0] o_meas;
  logic            o_valid, o_timeout, o_busy;
  state_e          o_dbg_state;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   start_q[$];

  delay_meas #(.TICKS_PER_MS(TPM), .MS_W(MS_W)) dut (
    .i_clk_1k    (i_clk_1k),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_done      (i_done),
    .i_limit     (i_limit),
    .o_meas      (o_meas),
    .o_valid     (o_valid),
    .o_timeout   (o_timeout),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk_1k = ~i_clk_1k;
  always @(posedge i_clk_1k) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got time %0t, required < 2000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Earliest of abort / done / timeout wins; ties resolved abort > done > timeout.
  function automatic logic [EW-1:0] model(input int limit, input int d, input int t, input int e0);
    int k_ab, k_dn, k_to, k, meas;
    logic [1:0] flags;
    k_ab = t - 2;
    k_dn = INF;
    k_to = INF;
    if (d >= 0 && d < t) k_dn = (d - 2 < 1) ? 1 : d - 2;
    if (limit != 0) k_to = limit * TPM;
    if (k_ab <= k_dn && k_ab <= k_to) begin
      flags = 2'b00; meas = 0; k = k_ab;
    end else if (k_dn <= k_to) begin
      flags = 2'b10; meas = k_dn / TPM; k = k_dn;
      if (meas > MS_MAX) meas = MS_MAX;
    end else begin
      flags = 2'b01; meas = limit; k = k_to;
    end
    return {flags, MS_W'(meas), 32'(e0 + 5 + k)};
  endfunction

  // ---------------- driver ----------------
  // limit latched at start; done pin rises d cycles after start (d<0: never);
  // start and done drop t cycles after start, then a quiet gap.
  task automatic run_txn(input int limit, input int d, input int t);
    int e0;
    @(posedge i_clk_1k); #1;
    e0      = cyc;
    i_limit = MS_W'(limit);
    i_start = 1'b1;
    if (d == 0) i_done = 1'b1;
    start_q.push_back(32'(e0 + 4));
    exp_q.push_back(model(limit, d, t, e0));
    for (int c = 1; c <= t; c++) begin
      @(posedge i_clk_1k); #1;
      if (c == d) i_done = 1'b1;
      if (c == 5) i_limit = MS_W'($urandom_range(0, MS_MAX));
      if (c == t) begin
        i_start = 1'b0;
        i_done  = 1'b0;
      end
    end
    repeat (6) @(posedge i_clk_1k);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_busy = 1'b0;
  always @(negedge i_clk_1k) begin
    logic [EW-1:0] e;
    if (i_rst) begin
      prev_busy = 1'b0;
    end else begin
      if (o_busy && !prev_busy) begin
        if (start_q.size() == 0) chk("unexpected_busy_rise", 1, 0);
        else begin
          chk("busy_rise_cycle", cyc, start_q.pop_front());
          chk("start_clears_flags", {o_valid, o_timeout}, 0);
          chk("start_clears_meas", o_meas, 0);
        end
      end
      if (!o_busy && prev_busy) begin
        if (exp_q.size() == 0) chk("unexpected_busy_fall", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("end_cycle", cyc, e[31:0]);
          chk("end_flags_valid_timeout", {o_valid, o_timeout}, e[EW-1 -: 2]);
          chk("end_meas", o_meas, e[32 +: MS_W]);
        end
      end
      prev_busy = o_busy;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lim, d, t;
    repeat (3) @(posedge i_clk_1k);
    #1;
    chk("reset_outputs", {o_meas, o_valid, o_timeout, o_busy}, 0);
    chk("reset_state", o_dbg_state, IDLE);
    @(posedge i_clk_1k); #1;
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk_1k);

    // 1) done 14 RUN cycles after entry -> 7 ms, valid
    run_txn(10, 16, 30);
    // 5a) falling start while in DONE changes nothing
    chk("hold_after_fall_valid", {o_valid, o_timeout, o_busy}, 3'b100);
    chk("hold_after_fall_meas", o_meas, 7);
    // 2) timeout at limit 3
    run_txn(3, -1, 20);
    // 3) done already high at start
    run_txn(5, 0, 10);
    // 4) abort, no limit
    run_txn(0, -1, 5);
    // done and timeout in the same cycle: done wins
    run_txn(5, 12, 20);
    // done just before timeout / just after
    run_txn(4, 9, 20);
    run_txn(4, 11, 20);

    // 5b) reset mid-RUN
    @(posedge i_clk_1k); #1;
    i_limit = '0;
    i_start = 1'b1;
    start_q.push_back(32'(cyc + 4));
    repeat (8) @(posedge i_clk_1k);
    #1;
    i_rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_reset_outputs", {o_meas, o_valid, o_timeout, o_busy}, 0);
    chk("async_reset_state", o_dbg_state, IDLE);
    i_start = 1'b0;
    @(posedge i_clk_1k); #1;
    i_rst = 1'b0;
    // 5c) done without a start does nothing
    i_done = 1'b1;
    repeat (8) @(posedge i_clk_1k);
    #1;
    chk("done_without_start", {o_meas, o_valid, o_timeout, o_busy}, 0);
    chk("done_without_start_state", o_dbg_state, IDLE);
    i_done = 1'b0;
    repeat (6) @(posedge i_clk_1k);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      lim = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 25);
      d   = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 60);
      t   = $urandom_range(4, 70);
      run_txn(lim, d, t);
    end

    // 6) saturation of ms counter, no limit
    run_txn(0, 8202, 8210);

    repeat (4) @(posedge i_clk_1k);
    chk("pending_end_events", exp_q.size(), 0);
    chk("pending_start_events", start_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
